// File: rtl/head_sram_arb.sv
// Head SRAM arbiter: independent round-robin read/write arbitration, registered SRAM commands, tagged read return.
// Define HEAD_SRAM_ARB_HOST_PRIO_EN to give requester 0 strict priority on both ports.

module head_sram_arb #(
   parameter int REQ_NUM    = 3,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 128,
   parameter int RD_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [REQ_NUM-1:0]            req_ren,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_raddr,
   output logic [REQ_NUM-1:0]            req_rgnt,
   output logic [REQ_NUM-1:0]            req_rvalid,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   input  logic [REQ_NUM-1:0]            req_wen,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_waddr,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] req_wdata,
   input  logic [REQ_NUM*DATA_WIDTH-1:0] req_bwe,
   output logic [REQ_NUM-1:0]            req_wgnt,
   output logic                          sram_ren,
   output logic [ADDR_WIDTH-1:0]         sram_raddr,
   input  logic [DATA_WIDTH-1:0]         sram_rdata,
   output logic                          sram_wen,
   output logic [ADDR_WIDTH-1:0]         sram_waddr,
   output logic [DATA_WIDTH-1:0]         sram_wdata,
   output logic [DATA_WIDTH-1:0]         sram_bwe
);

   localparam int PTR_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int TAG_DEPTH = 1 + RD_LATENCY;

   typedef struct packed {
      logic             vld;
      logic             adv;
      logic [PTR_W-1:0] idx;
   } arb_t;

   typedef struct packed {
      logic             vld;
      logic [PTR_W-1:0] idx;
   } tag_t;

   // Search upward from ptr (mod REQ_NUM); cand stays below 2*REQ_NUM so one extra bit suffices.
   function automatic arb_t arbitrate(input logic [REQ_NUM-1:0] req, input logic [PTR_W-1:0] ptr);
      arb_t           res;
      logic [PTR_W:0] cand;
      res = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         cand = {1'b0, ptr} + (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(REQ_NUM)) begin
            cand = cand - (PTR_W+1)'(REQ_NUM);
         end
         if (!res.vld && req[cand[PTR_W-1:0]]) begin
            res.vld = 1'b1;
            res.adv = 1'b1;
            res.idx = cand[PTR_W-1:0];
         end
      end
`ifdef HEAD_SRAM_ARB_HOST_PRIO_EN
      if (req[0]) begin
         res.vld = 1'b1;
         res.adv = 1'b0;
         res.idx = '0;
      end
`endif
      return res;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
      if (idx == PTR_W'(REQ_NUM-1)) begin
         return '0;
      end
      return idx + PTR_W'(1);
   endfunction

   function automatic logic [REQ_NUM-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [REQ_NUM-1:0] oh;
      for (int i = 0; i < REQ_NUM; i++) begin
         oh[i] = (idx == PTR_W'(i));
      end
      return oh;
   endfunction

   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   arb_t                  rd_arb_s, wr_arb_s;
   logic [ADDR_WIDTH-1:0] raddr_sel_s, waddr_sel_s;
   logic [DATA_WIDTH-1:0] wdata_sel_s, bwe_sel_s;
   logic                  sram_ren_q, sram_wen_q;
   logic [ADDR_WIDTH-1:0] sram_raddr_q, sram_waddr_q;
   logic [DATA_WIDTH-1:0] sram_wdata_q, sram_bwe_q;
   tag_t                  tag_q [TAG_DEPTH];

   // Grants are forced low during reset by masking the requests.
   always_comb begin
      rd_arb_s = arbitrate(req_ren & {REQ_NUM{rstn}}, rd_ptr_q);
      wr_arb_s = arbitrate(req_wen & {REQ_NUM{rstn}}, wr_ptr_q);
      if (rd_arb_s.vld) begin
         req_rgnt = onehot(rd_arb_s.idx);
      end else begin
         req_rgnt = '0;
      end
      if (wr_arb_s.vld) begin
         req_wgnt = onehot(wr_arb_s.idx);
      end else begin
         req_wgnt = '0;
      end
      if (rd_arb_s.adv) begin
         rd_ptr_d = ptr_next(rd_arb_s.idx);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (wr_arb_s.adv) begin
         wr_ptr_d = ptr_next(wr_arb_s.idx);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
   end

   // AND-OR select of the granted requester's command fields.
   always_comb begin
      raddr_sel_s = '0;
      waddr_sel_s = '0;
      wdata_sel_s = '0;
      bwe_sel_s   = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         raddr_sel_s = raddr_sel_s | (req_raddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{rd_arb_s.idx == PTR_W'(i)}});
         waddr_sel_s = waddr_sel_s | (req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{wr_arb_s.idx == PTR_W'(i)}});
         wdata_sel_s = wdata_sel_s | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{wr_arb_s.idx == PTR_W'(i)}});
         bwe_sel_s   = bwe_sel_s   | (req_bwe[i*DATA_WIDTH +: DATA_WIDTH]   & {DATA_WIDTH{wr_arb_s.idx == PTR_W'(i)}});
      end
   end

   // Arbiter pointers and registered SRAM command; idle cycles hold address/data but drop enables and bwe.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         sram_ren_q   <= 1'b0;
         sram_wen_q   <= 1'b0;
         sram_raddr_q <= '0;
         sram_waddr_q <= '0;
         sram_wdata_q <= '0;
         sram_bwe_q   <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         sram_ren_q <= rd_arb_s.vld;
         sram_wen_q <= wr_arb_s.vld;
         if (rd_arb_s.vld) begin
            sram_raddr_q <= raddr_sel_s;
         end
         if (wr_arb_s.vld) begin
            sram_waddr_q <= waddr_sel_s;
            sram_wdata_q <= wdata_sel_s;
            sram_bwe_q   <= bwe_sel_s;
         end else begin
            sram_bwe_q   <= '0;
         end
      end
   end

   // Read tag pipeline; stage RD_LATENCY lines up with sram_rdata, reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < TAG_DEPTH; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         tag_q[0] <= {rd_arb_s.vld, rd_arb_s.idx};
         for (int s = 1; s < TAG_DEPTH; s++) begin
            tag_q[s] <= tag_q[s-1];
         end
      end
   end

   // One-hot read-valid decode of the aligned tag stage.
   always_comb begin
      if (tag_q[RD_LATENCY].vld) begin
         req_rvalid = onehot(tag_q[RD_LATENCY].idx);
      end else begin
         req_rvalid = '0;
      end
   end

   assign req_rdata  = sram_rdata;
   assign sram_ren   = sram_ren_q;
   assign sram_raddr = sram_raddr_q;
   assign sram_wen   = sram_wen_q;
   assign sram_waddr = sram_waddr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_bwe   = sram_bwe_q;

endmodule

// File: tb/tb_head_sram_arb.sv
// Scoreboard bench for head_sram_arb: directed test-plan phases plus random traffic against a reference model.
// Expected SRAM commands and read returns are queued at grant time and popped by an output monitor.

module tb_head_sram_arb;

   localparam int N   = 3;
   localparam int AW  = 9;
   localparam int DW  = 128;
   localparam int RDL = 1;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [N-1:0]    req_ren = '0, req_wen = '0;
   logic [N*AW-1:0] req_raddr = '0, req_waddr = '0;
   logic [N*DW-1:0] req_wdata = '0, req_bwe = '0;
   logic [N-1:0]    req_rgnt, req_wgnt, req_rvalid;
   logic [DW-1:0]   req_rdata;
   logic            sram_ren, sram_wen;
   logic [AW-1:0]   sram_raddr, sram_waddr;
   logic [DW-1:0]   sram_rdata = '0, sram_wdata, sram_bwe;

   head_sram_arb #(.REQ_NUM(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL)) dut (
      .clk(clk), .rstn(rstn),
      .req_ren(req_ren), .req_raddr(req_raddr), .req_rgnt(req_rgnt),
      .req_rvalid(req_rvalid), .req_rdata(req_rdata),
      .req_wen(req_wen), .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_bwe(req_bwe), .req_wgnt(req_wgnt),
      .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
      .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
      .sram_bwe(sram_bwe)
   );

   always #5 clk = ~clk;

   // SRAM macro stand-in: one-cycle registered read, read-before-write on collisions
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (sram_ren === 1'b1) sram_rdata <= mem[sram_raddr];
      if (sram_wen === 1'b1) mem[sram_waddr] <= (mem[sram_waddr] & ~sram_bwe) | (sram_wdata & sram_bwe);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int            due;
      int            idx;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] bwe;
   } exp_t;

   exp_t rdq[$];
   exp_t wrq[$];
   exp_t rvq[$];

   // Reference state
   int            rd_ptr = 0;
   int            wr_ptr = 0;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];

   // Stimulus state: a pending request stays asserted until the model sees it granted
   bit            rstn_v = 1'b0;
   bit            rd_pend [N];
   bit            wr_pend [N];
   logic [AW-1:0] rd_a [N];
   logic [AW-1:0] wr_a [N];
   logic [DW-1:0] wr_d [N];
   logic [DW-1:0] wr_b [N];

   function automatic int pick(input int req, input int ptr);
`ifdef HEAD_SRAM_ARB_HOST_PRIO_EN
      if ((req & 1) != 0) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         if (((req >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int next_ptr(input int g, input int ptr);
`ifdef HEAD_SRAM_ARB_HOST_PRIO_EN
      if (g == 0) return ptr;
`endif
      return (g + 1) % N;
   endfunction

   task automatic drive();
      logic [N*AW-1:0] ta;
      logic [N*DW-1:0] td;
      rstn = rstn_v;
      req_ren = '0; req_wen = '0;
      req_raddr = '0; req_waddr = '0; req_wdata = '0; req_bwe = '0;
      for (int i = 0; i < N; i++) begin
         if (rd_pend[i]) req_ren = req_ren | (N'(1) << i);
         if (wr_pend[i]) req_wen = req_wen | (N'(1) << i);
         ta = '0; ta[AW-1:0] = rd_a[i]; req_raddr = req_raddr | (ta << (i*AW));
         ta = '0; ta[AW-1:0] = wr_a[i]; req_waddr = req_waddr | (ta << (i*AW));
         td = '0; td[DW-1:0] = wr_d[i]; req_wdata = req_wdata | (td << (i*DW));
         td = '0; td[DW-1:0] = wr_b[i]; req_bwe   = req_bwe   | (td << (i*DW));
      end
   endtask

   task automatic model_and_check();
      int   rreq, wreq, gr, gw;
      exp_t e;
      rreq = 0; wreq = 0;
      for (int i = 0; i < N; i++) begin
         if (rd_pend[i]) rreq = rreq | (1 << i);
         if (wr_pend[i]) wreq = wreq | (1 << i);
      end
      gr = rstn_v ? pick(rreq, rd_ptr) : -1;
      gw = rstn_v ? pick(wreq, wr_ptr) : -1;
      chk("rgnt", req_rgnt, (gr >= 0) ? DW'(1 << gr) : '0);
      chk("wgnt", req_wgnt, (gw >= 0) ? DW'(1 << gw) : '0);
      if (!rstn_v) begin
         rd_ptr = 0; wr_ptr = 0;
         while (rdq.size() > 0 && rdq[$].due > cyc) void'(rdq.pop_back());
         while (wrq.size() > 0 && wrq[$].due > cyc) void'(wrq.pop_back());
         while (rvq.size() > 0 && rvq[$].due > cyc) void'(rvq.pop_back());
      end else begin
         if (gr >= 0) begin
            e.due = cyc + 1; e.idx = gr; e.addr = rd_a[gr]; e.data = '0; e.bwe = '0;
            rdq.push_back(e);
            e.due = cyc + 1 + RDL; e.data = ref_mem[rd_a[gr]];
            rvq.push_back(e);
            rd_pend[gr] = 1'b0;
            rd_ptr = next_ptr(gr, rd_ptr);
         end
         if (gw >= 0) begin
            e.due = cyc + 1; e.idx = gw; e.addr = wr_a[gw]; e.data = wr_d[gw]; e.bwe = wr_b[gw];
            wrq.push_back(e);
            ref_mem[wr_a[gw]] = (ref_mem[wr_a[gw]] & ~wr_b[gw]) | (wr_d[gw] & wr_b[gw]);
            wr_pend[gw] = 1'b0;
            wr_ptr = next_ptr(gw, wr_ptr);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      model_and_check();
   endtask

   // Output monitor: pops an expectation whenever the DUT presents a command or read return
   always @(negedge clk) begin
      exp_t m;
      if (sram_ren === 1'b1) begin
         if (rdq.size() == 0) chk("rd_cmd_spurious", DW'(sram_ren), '0);
         else begin
            m = rdq.pop_front();
            chk("rd_cmd_cycle", DW'(cyc), DW'(m.due));
            chk("rd_cmd_addr", DW'(sram_raddr), DW'(m.addr));
         end
      end else if (rdq.size() > 0 && rdq[0].due <= cyc) begin
         m = rdq.pop_front();
         chk("rd_cmd_missing", DW'(sram_ren), DW'(1));
      end
      if (sram_wen === 1'b1) begin
         if (wrq.size() == 0) chk("wr_cmd_spurious", DW'(sram_wen), '0);
         else begin
            m = wrq.pop_front();
            chk("wr_cmd_cycle", DW'(cyc), DW'(m.due));
            chk("wr_cmd_addr", DW'(sram_waddr), DW'(m.addr));
            chk("wr_cmd_data", sram_wdata, m.data);
            chk("wr_cmd_bwe", sram_bwe, m.bwe);
         end
      end else begin
         if (sram_wen === 1'b0) chk("bwe_idle", sram_bwe, '0);
         if (wrq.size() > 0 && wrq[0].due <= cyc) begin
            m = wrq.pop_front();
            chk("wr_cmd_missing", DW'(sram_wen), DW'(1));
         end
      end
      if (req_rvalid !== '0 && !$isunknown(req_rvalid)) begin
         if (rvq.size() == 0) chk("rvalid_spurious", DW'(req_rvalid), '0);
         else begin
            m = rvq.pop_front();
            chk("rvalid_cycle", DW'(cyc), DW'(m.due));
            chk("rvalid_vec", DW'(req_rvalid), DW'(1 << m.idx));
            chk("rdata", req_rdata, m.data);
         end
      end else if (rvq.size() > 0 && rvq[0].due <= cyc) begin
         m = rvq.pop_front();
         chk("rvalid_missing", DW'(req_rvalid), DW'(1 << m.idx));
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   logic [N-1:0] rr_exp [6];
   logic [N-1:0] alt_exp [6];

   initial begin
      for (int a = 0; a < (1 << AW); a++) begin
         mem[a] = '0;
         ref_mem[a] = '0;
      end
      for (int i = 0; i < N; i++) begin
         rd_pend[i] = 1'b0; wr_pend[i] = 1'b0;
         rd_a[i] = '0; wr_a[i] = '0; wr_d[i] = '0; wr_b[i] = '0;
      end
`ifdef HEAD_SRAM_ARB_HOST_PRIO_EN
      rr_exp  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      alt_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
      rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      alt_exp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif

      // Reset held 3 cycles with every request high
      rstn_v = 1'b0;
      for (int i = 0; i < N; i++) begin
         rd_pend[i] = 1'b1; wr_pend[i] = 1'b1;
         rd_a[i] = AW'(16 * (i + 1)); wr_a[i] = AW'(100 + i);
         wr_d[i] = {4{32'hC0DE0000 + 32'(i)}}; wr_b[i] = '1;
      end
      for (int k = 0; k < 3; k++) begin
         step();
         chk("reset_rgnt", DW'(req_rgnt), '0);
         chk("reset_sram_ren", DW'(sram_ren), '0);
         chk("reset_sram_wen", DW'(sram_wen), '0);
         chk("reset_rvalid", DW'(req_rvalid), '0);
      end
      rstn_v = 1'b1;
      for (int i = 0; i < N; i++) wr_pend[i] = 1'b0;

      // Round-robin over three continuous readers, addresses 0x10/0x20/0x30
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) rd_pend[i] = 1'b1;
         step();
         chk("rr_grant_seq", DW'(req_rgnt), DW'(rr_exp[k]));
      end
      for (int i = 0; i < N; i++) rd_pend[i] = 1'b0;
      idle(3);

      // Write 0xA5.. to address 5 from requester 2 then read it back
      wr_pend[2] = 1'b1; wr_a[2] = AW'(5); wr_d[2] = {16{8'hA5}}; wr_b[2] = '1;
      step();
      rd_pend[2] = 1'b1; rd_a[2] = AW'(5);
      step();
      chk("wb_read_grant", DW'(req_rgnt), DW'(3'b100));
      step();
      step();
      chk("wb_rvalid", DW'(req_rvalid), DW'(3'b100));
      chk("wb_rdata", req_rdata, {16{8'hA5}});
      // Low-half masked write
      wr_pend[2] = 1'b1; wr_d[2] = {16{8'h5A}}; wr_b[2] = {{64{1'b0}}, {64{1'b1}}};
      step();
      rd_pend[2] = 1'b1;
      step();
      step();
      step();
      chk("masked_rdata", req_rdata, {{8{8'hA5}}, {8{8'h5A}}});
      idle(2);

      // Independent ports: requester 0 reads while requester 1 writes
      for (int k = 0; k < 8; k++) begin
         rd_pend[0] = 1'b1; rd_a[0] = AW'($urandom_range(0, 31));
         wr_pend[1] = 1'b1; wr_a[1] = AW'($urandom_range(0, 31));
         wr_d[1] = {$urandom, $urandom, $urandom, $urandom}; wr_b[1] = '1;
         step();
         chk("indep_rgnt", DW'(req_rgnt), DW'(3'b001));
         chk("indep_wgnt", DW'(req_wgnt), DW'(3'b010));
      end
      idle(3);

      // Reset one cycle after a read grant: the read must never return
      rd_pend[0] = 1'b1; rd_a[0] = AW'(7);
      step();
      rstn_v = 1'b0;
      step();
      rstn_v = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("midflight_no_rvalid", DW'(req_rvalid), '0);
      end

      // Requesters 0 and 1 read continuously from a fresh pointer
      rstn_v = 1'b0;
      step();
      rstn_v = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rd_pend[0] = 1'b1; rd_pend[1] = 1'b1;
         rd_a[0] = AW'(40 + k); rd_a[1] = AW'(50 + k);
         step();
         chk("prio_alt_grant", DW'(req_rgnt), DW'(alt_exp[k]));
      end
      rd_pend[0] = 1'b0; rd_pend[1] = 1'b0;
      idle(3);

      // Random traffic with sticky requests and rare resets
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!rd_pend[i] && $urandom_range(0, 3) != 0) begin
               rd_pend[i] = 1'b1; rd_a[i] = AW'($urandom_range(0, 15));
            end
            if (!wr_pend[i] && $urandom_range(0, 2) == 0) begin
               wr_pend[i] = 1'b1; wr_a[i] = AW'($urandom_range(0, 15));
               wr_d[i] = {$urandom, $urandom, $urandom, $urandom};
               case ($urandom_range(0, 2))
                  0: wr_b[i] = '1;
                  1: wr_b[i] = {{64{1'b0}}, {64{1'b1}}};
                  default: wr_b[i] = {$urandom, $urandom, $urandom, $urandom};
               endcase
            end
         end
         rstn_v = ($urandom_range(0, 299) != 0);
         step();
      end
      rstn_v = 1'b1;
      for (int i = 0; i < N; i++) begin
         rd_pend[i] = 1'b0; wr_pend[i] = 1'b0;
      end
      idle(6);
      chk("rdq_drained", DW'(rdq.size()), '0);
      chk("wrq_drained", DW'(wrq.size()), '0);
      chk("rvq_drained", DW'(rvq.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
